accu_seq_4: RTL and testbench

ACCU_SEQ_4 -- requirements
Module: accu_seq_4

---
 rtl/accu_seq_4.sv | 228 ++++++++++++++++++++++
 tb/tb_accu_seq_4.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accu_seq_4.sv
// accu_seq_4: command sequencer for an external 4-bit accumulator.
// It executes LOAD, ADD, SUB and MUL commands. MUL is performed as a clear
// followed by N repeated additions. A sticky overflow flag is reported
// together with the result.
// Optional feature: defining ACCU_SEQ_CMD_FIFO_EN adds a 2-entry command
// FIFO, so commands are accepted while a command is executing and the next
// command is dispatched straight out of DONE.
module accu_seq_4 (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_CMD_VALID,
  output logic       o_CMD_READY,
  input  logic [1:0] i_CMD_OP,
  input  logic [3:0] i_CMD_D,
  input  logic [3:0] i_CMD_N,
  output logic       o_ACC_EN,
  output logic [1:0] o_ACC_C,
  output logic [3:0] o_ACC_D,
  input  logic [3:0] i_ACC_Q,
  input  logic       i_ACC_CARRY,
  output logic       o_BUSY,
  output logic       o_DONE,
  output logic [3:0] o_RESULT,
  output logic       o_OVF
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic [1:0] op_q, op_d;
  logic [3:0] opnd_q, opnd_d;

  // Command that would start now, and whether it starts this cycle
  logic       cmd_ready;
  logic       start;
  logic [1:0] head_op;
  logic [3:0] head_d;
  logic [3:0] head_n;

  logic       acc_en;
  logic [1:0] acc_c;
  logic [3:0] acc_d;

`ifdef ACCU_SEQ_CMD_FIFO_EN
  logic [9:0] fifo_mem_q [2];
  logic [9:0] fifo_mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] fifo_cnt_q, fifo_cnt_d;
  logic       fifo_empty;
  logic       fifo_full;
  logic       push_req;
  logic       push;
  logic       pop;

  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign fifo_full  = (fifo_cnt_q == 2'd2);
  assign cmd_ready  = !i_RST && !fifo_full;
  assign push_req   = i_CMD_VALID && cmd_ready;
  // An empty FIFO is bypassed so an idle sequencer starts on the accept edge
  assign start      = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                      (!fifo_empty || push_req);
  assign pop        = start && !fifo_empty;
  assign push       = push_req && !(start && fifo_empty);
  assign {head_op, head_d, head_n} = fifo_empty ? {i_CMD_OP, i_CMD_D, i_CMD_N}
                                                : fifo_mem_q[rd_ptr_q];

  // FIFO pointer, occupancy and storage update
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = {i_CMD_OP, i_CMD_D, i_CMD_N};
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // FIFO control state; reset empties the FIFO
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO entry storage (data only, no reset needed)
  always_ff @(posedge i_CLK) begin
    fifo_mem_q <= fifo_mem_d;
  end
`else
  assign cmd_ready = !i_RST && (state_q == ST_IDLE);
  assign start     = i_CMD_VALID && cmd_ready;
  assign head_op   = i_CMD_OP;
  assign head_d    = i_CMD_D;
  assign head_n    = i_CMD_N;
`endif

  // Sequencer next state, step counter and sticky overflow
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          op_d   = head_op;
          opnd_d = head_d;
          ovf_d  = 1'b0;
          if (head_op == OP_LOAD) begin
            cnt_d   = 4'd1;
            state_d = ST_STEP;
          end else begin
            cnt_d = head_n;
            if (head_op == OP_MUL) begin
              state_d = ST_CLEAR;
            end else if (head_n == 4'd0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_STEP;
            end
          end
        end
      end
      ST_CLEAR: begin
        state_d = (cnt_q == 4'd0) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        cnt_d = cnt_q - 4'd1;
        // For SUB the adder carry is an inverted borrow
        if (op_q == OP_SUB) begin
          if (!i_ACC_CARRY) begin
            ovf_d = 1'b1;
          end
        end else if (op_q != OP_LOAD) begin
          if (i_ACC_CARRY) begin
            ovf_d = 1'b1;
          end
        end
        if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state; reset aborts any command immediately
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Latched opcode and operand of the executing command
  always_ff @(posedge i_CLK) begin
    op_q   <= op_d;
    opnd_q <= opnd_d;
  end

  // Accumulator drive, decoded from the current state only
  always_comb begin
    acc_en = 1'b0;
    acc_c  = 2'b00;
    acc_d  = 4'd0;
    case (state_q)
      ST_CLEAR: begin
        acc_en = 1'b1;
        acc_c  = 2'b10;
      end
      ST_STEP: begin
        acc_en = 1'b1;
        acc_d  = opnd_q;
        case (op_q)
          OP_LOAD: acc_c = 2'b10;
          OP_SUB:  acc_c = 2'b01;
          default: acc_c = 2'b00;
        endcase
      end
      default: begin
        acc_en = 1'b0;
      end
    endcase
  end

  assign o_CMD_READY = cmd_ready;
  assign o_ACC_EN    = acc_en;
  assign o_ACC_C     = acc_c;
  assign o_ACC_D     = acc_d;
  assign o_BUSY      = (state_q != ST_IDLE);
  assign o_DONE      = (state_q == ST_DONE);
  assign o_RESULT    = (state_q == ST_DONE) ? i_ACC_Q : 4'd0;
  assign o_OVF       = ovf_q;

endmodule

// File: tb/tb_accu_seq_4.sv
// Testbench for accu_seq_4: models the external accumulator and checks each
// command against an arithmetic reference (result, overflow, latency).
module tb_accu_seq_4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_d;
  logic [3:0] cmd_n;
  logic       acc_en;
  logic [1:0] acc_c;
  logic [3:0] acc_d;
  logic [3:0] acc_q = 4'd0;
  logic       acc_carry;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  accu_seq_4 dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_CMD_VALID (cmd_valid),
    .o_CMD_READY (cmd_ready),
    .i_CMD_OP    (cmd_op),
    .i_CMD_D     (cmd_d),
    .i_CMD_N     (cmd_n),
    .o_ACC_EN    (acc_en),
    .o_ACC_C     (acc_c),
    .o_ACC_D     (acc_d),
    .i_ACC_Q     (acc_q),
    .i_ACC_CARRY (acc_carry),
    .o_BUSY      (busy),
    .o_DONE      (done),
    .o_RESULT    (result),
    .o_OVF       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External accumulator: load, add or subtract; contents survive reset
  always @(posedge clk) begin
    if (acc_en) begin
      if (acc_c[1]) acc_q <= acc_d;
      else if (acc_c[0]) acc_q <= acc_q - acc_d;
      else acc_q <= acc_q + acc_d;
    end
  end

  logic [4:0] sum5;
  assign sum5      = acc_c[0] ? ({1'b0, acc_q} + {1'b0, ~acc_d} + 5'd1)
                              : ({1'b0, acc_q} + {1'b0, acc_d});
  assign acc_carry = sum5[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Whole-command reference: final value, overflow, done latency, enable count
  function automatic void model(input int op, input int d, input int n, input int q,
                                output logic [3:0] res, output logic ov,
                                output int lat, output int en);
    int t;
    case (op)
      0: begin t = d;         ov = 1'b0;     lat = 2;                     en = 1;     end
      1: begin t = q + d * n; ov = (t > 15); lat = (n == 0) ? 1 : n + 1;  en = n;     end
      2: begin t = q - d * n; ov = (t < 0);  lat = (n == 0) ? 1 : n + 1;  en = n;     end
      default: begin
               t = d * n;     ov = (t > 15); lat = n + 2;                 en = n + 1; end
    endcase
    res = t[3:0];
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] d, input logic [3:0] n,
                         input string tag);
    int waitc, lat, en_cnt, exp_lat, exp_en;
    logic [3:0] exp_res;
    logic exp_ovf, got_done, en1;
    logic [1:0] c1;
    logic [3:0] d1;
    waitc = 0;
    @(negedge clk);
    while (!cmd_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk({tag, "_ready"}, cmd_ready, 1);
    if (!cmd_ready) return;
    model(int'(op), int'(d), int'(n), int'(acc_q), exp_res, exp_ovf, exp_lat, exp_en);
    en1 = !((op == 2'b01 || op == 2'b10) && n == 4'd0);
    if (!en1) c1 = 2'b00;
    else if (op == 2'b00 || op == 2'b11) c1 = 2'b10;
    else if (op == 2'b10) c1 = 2'b01;
    else c1 = 2'b00;
    d1 = (!en1 || op == 2'b11) ? 4'd0 : d;
    cmd_valid = 1'b1; cmd_op = op; cmd_d = d; cmd_n = n;
    @(posedge clk); #1;
    // Scramble the inputs: a registered command must not notice
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_d = 4'($urandom); cmd_n = 4'($urandom);
    lat = 0; en_cnt = 0; got_done = 1'b0;
    while (!got_done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk({tag, "_en1"}, acc_en, en1);
        chk({tag, "_c1"}, acc_c, c1);
        chk({tag, "_d1"}, acc_d, d1);
      end
      if (acc_en) en_cnt++;
      if (done) begin
        got_done = 1'b1;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_ovf"}, ovf, exp_ovf);
        chk({tag, "_steps"}, en_cnt, exp_en);
        chk({tag, "_busy_done"}, busy, 1);
        chk({tag, "_idle_drive"}, {acc_en, acc_c, acc_d}, 0);
      end else begin
        chk({tag, "_busy"}, busy, 1);
      end
`ifndef ACCU_SEQ_CMD_FIFO_EN
      chk({tag, "_nordy"}, cmd_ready, 0);
`endif
    end
    chk({tag, "_done"}, got_done, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

`ifdef ACCU_SEQ_CMD_FIFO_EN
  task automatic fifo_test();
    logic [1:0] ops [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
    logic [3:0] ds  [4] = '{4'd1, 4'd5, 4'd2, 4'd3};
    logic [3:0] ns  [4] = '{4'd4, 4'd2, 4'd3, 4'd2};
    logic [3:0] exp_res [$];
    logic       exp_ovf [$];
    logic [3:0] r;
    logic       o;
    int q, lat, en, first_done, third_acc, dones;
    q = int'(acc_q);
    for (int i = 0; i < 4; i++) begin
      model(int'(ops[i]), int'(ds[i]), int'(ns[i]), q, r, o, lat, en);
      exp_res.push_back(r);
      exp_ovf.push_back(o);
      q = int'(r);
    end
    first_done = -1; third_acc = -1; dones = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int w;
          w = 0;
          @(negedge clk);
          cmd_valid = 1'b1; cmd_op = ops[i]; cmd_d = ds[i]; cmd_n = ns[i];
          while (!cmd_ready && w < 60) begin
            @(negedge clk);
            w++;
          end
          if (i == 3) third_acc = cyc;
          @(posedge clk); #1;
          cmd_valid = 1'b0;
        end
      end
      begin
        int k;
        logic want_en;
        k = 0; want_en = 1'b0;
        while (dones < 4 && k < 300) begin
          @(negedge clk);
          k++;
          if (want_en) chk("fifo_no_gap", acc_en, 1);
          want_en = 1'b0;
          if (done) begin
            if (dones == 0) first_done = cyc;
            chk("fifo_res", result, exp_res.pop_front());
            chk("fifo_ovf", ovf, exp_ovf.pop_front());
            dones++;
            want_en = (dones < 4);
          end
        end
      end
    join
    chk("fifo_all_done", dones, 4);
    chk("fifo_third_stall", (third_acc > first_done) && (first_done >= 0), 1);
  endtask
`endif

  initial begin
    logic saw_done;
    logic [1:0] rop;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_d = 4'd0; cmd_n = 4'd0;
    #12;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_en", acc_en, 0);
    chk("rst_drive", {acc_c, acc_d}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);

    run_cmd(2'b00, 4'd5, 4'd9, "load5");
    run_cmd(2'b00, 4'd1, 4'd0, "load1");
    run_cmd(2'b01, 4'd2, 4'd3, "add_1p6");
    run_cmd(2'b00, 4'd14, 4'd0, "load14");
    run_cmd(2'b01, 4'd3, 4'd1, "add_wrap");
    run_cmd(2'b00, 4'd2, 4'd0, "load2");
    run_cmd(2'b10, 4'd3, 4'd1, "sub_borrow");
    run_cmd(2'b11, 4'd3, 4'd5, "mul15");
    run_cmd(2'b11, 4'd4, 4'd5, "mul_ovf");
    run_cmd(2'b01, 4'd7, 4'd0, "add_n0");
    run_cmd(2'b11, 4'd9, 4'd0, "mul_n0");
    run_cmd(2'b10, 4'd0, 4'd3, "sub_zero");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      run_cmd(rop, 4'($urandom), 4'($urandom_range(0, 6)), "rand");
    end

`ifdef ACCU_SEQ_CMD_FIFO_EN
    fifo_test();
`endif

    // Reset in the middle of a long ADD
    run_cmd(2'b00, 4'd0, 4'd0, "load0");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_d = 4'd1; cmd_n = 4'd8;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_step_en", acc_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_en", acc_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", cmd_ready, 1);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    run_cmd(2'b01, 4'd2, 4'd2, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
